// File: rtl/cc1200_spi_arbiter.sv
`default_nettype none
// ============================================================================
// cc1200_spi_arbiter - round-robin sharing of one CC1200 SPI byte engine
// Rev 1.0
// ============================================================================
module cc1200_spi_arbiter #(
  parameter int NREQ    = 3,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   len,
  input  logic [8*NREQ-1:0]   tx_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     byte_next,
  output logic [7:0]          rx_data,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic                spi_start,
  output logic                spi_stop,
  output logic [7:0]          spi_dout,
  input  logic [7:0]          spi_din,
  input  logic                spi_load_next,
  input  logic                spi_busy,
  input  logic                spi_cs_n
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [7:0]        lenq_q, lenq_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        gap_q, gap_d;
  logic [15:0]       to_q, to_d;
  logic              abort_q, abort_d;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  int                cand;
  logic [7:0]        len_pick;
  logic              last_byte;

  // Scan from the highest offset down so the earliest candidate after rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  assign len_pick  = len[{pick_idx, 3'b000} +: 8];
  assign last_byte = (byte_q == lenq_q - 8'd1);
  assign rx_data   = spi_din;
  assign spi_dout  = (gnt_q != '0) ? tx_data[{owner_q, 3'b000} +: 8] : 8'h00;
  assign gnt       = gnt_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    lenq_d    = lenq_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    to_d      = to_q;
    abort_d   = abort_q;
    spi_start = 1'b0;
    spi_stop  = 1'b0;
    byte_next = '0;
    done      = '0;
    err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          lenq_d  = (len_pick == 8'd0) ? 8'd1 : len_pick;
          state_d = S_START;
        end
      end
      S_START: begin
        spi_start = 1'b1;
        byte_d    = 8'd0;
        to_d      = 16'd0;
        state_d   = S_XFER;
      end
      S_XFER: begin
        spi_stop = last_byte;
        if (spi_load_next) begin
          byte_next = gnt_q;
          byte_d    = byte_q + 8'd1;
          to_d      = 16'd0;
          if (last_byte) state_d = S_DRAIN;
        end else if (to_q >= 16'(TIMEOUT - 1)) begin
          // Stalled engine: stop it now and let the normal drain/gap path finish.
          abort_d  = 1'b1;
          spi_stop = 1'b1;
          to_d     = 16'(TIMEOUT);
          state_d  = S_DRAIN;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_DRAIN: begin
        spi_stop = 1'b1;
        if (spi_cs_n && !spi_busy) begin
          gap_d   = 8'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 8'(GAP)) begin
          done    = gnt_q;
          err     = abort_q;
          gnt_d   = '0;
          abort_d = 1'b0;
          rr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      lenq_q  <= 8'd0;
      byte_q  <= 8'd0;
      gap_q   <= 8'd0;
      to_q    <= 16'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lenq_q  <= lenq_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      abort_q <= abort_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cc1200_spi_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cc1200_spi_arbiter - directed bench with a small CC1200 byte-engine model
// Rev 1.0
// ============================================================================
module tb_cc1200_spi_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  req;
  logic [23:0] len;
  logic [23:0] tx_data;
  logic [2:0]  gnt;
  logic [2:0]  byte_next;
  logic [7:0]  rx_data;
  logic [2:0]  done;
  logic        err;
  logic        spi_start;
  logic        spi_stop;
  logic [7:0]  spi_dout;
  logic [7:0]  spi_din;
  logic        spi_load_next;
  logic        spi_busy;
  logic        spi_cs_n;

  cc1200_spi_arbiter #(.NREQ(3), .GAP(4), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .len(len), .tx_data(tx_data),
    .gnt(gnt), .byte_next(byte_next), .rx_data(rx_data), .done(done), .err(err),
    .spi_start(spi_start), .spi_stop(spi_stop), .spi_dout(spi_dout),
    .spi_din(spi_din), .spi_load_next(spi_load_next), .spi_busy(spi_busy),
    .spi_cs_n(spi_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // engine model state
  int         e_st, e_cnt, din_idx;
  bit         nostrobe, drop_on_first;
  logic       prev_start, prev_stop, prev_cs;
  logic [7:0] din_tab [4];

  // per-transaction records
  int         bn_total, bn2_cyc, stop_rise_cyc, start_cyc, cs_rise_cyc, done_cyc;
  int         done_pulses, err_pulses, cs_high_run, run_at_start;
  int         bn_cnt [3];
  logic       stop_first_xfer, err_at_done;
  logic [2:0] done_vec;
  logic [7:0] rx_cap [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bn_total = 0; bn2_cyc = -1; stop_rise_cyc = -1; start_cyc = -1;
    cs_rise_cyc = -1; done_cyc = -1; done_pulses = 0; err_pulses = 0;
    run_at_start = 0; stop_first_xfer = 1'b0; err_at_done = 1'b0; done_vec = '0;
    for (int i = 0; i < 3; i++) bn_cnt[i] = 0;
    for (int i = 0; i < 8; i++) rx_cap[i] = 8'h00;
  endtask

  // One clock: engine model drives its inputs, then outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    spi_load_next = 1'b0;
    if (!rstn) begin
      e_st = 0; spi_cs_n = 1'b1; spi_busy = 1'b0;
    end else begin
      case (e_st)
        0: if (prev_start) begin
             spi_cs_n = 1'b0; spi_busy = 1'b1; e_st = 1; e_cnt = 0;
           end
        1: if (!nostrobe) begin
             e_cnt++;
             if (e_cnt == 2) begin
               e_cnt = 0; spi_load_next = 1'b1;
               spi_din = din_tab[din_idx % 4]; din_idx++;
             end
           end else if (prev_stop) begin
             e_st = 2; e_cnt = 0;
           end
        2: begin
             e_cnt++;
             if (e_cnt == 2) begin
               spi_cs_n = 1'b1; spi_busy = 1'b0; e_st = 0;
             end
           end
        default: e_st = 0;
      endcase
    end
    #1;
    if (e_st == 1 && spi_load_next && spi_stop) begin
      e_st = 2; e_cnt = 0;
    end
    if (spi_cs_n) cs_high_run++; else cs_high_run = 0;
    if (spi_cs_n && !prev_cs) cs_rise_cyc = cyc;
    if (spi_start) begin start_cyc = cyc; run_at_start = cs_high_run; end
    if (start_cyc >= 0 && cyc == start_cyc + 1) stop_first_xfer = spi_stop;
    if (spi_stop && stop_rise_cyc < 0) stop_rise_cyc = cyc;
    if (byte_next != 3'b000) begin
      if (bn_total < 8) rx_cap[bn_total] = rx_data;
      bn_total++;
      if (bn_total == 2) bn2_cyc = cyc;
      for (int i = 0; i < 3; i++) if (byte_next[i]) bn_cnt[i]++;
      if (drop_on_first) req = 3'b000;
    end
    if (done != 3'b000) begin
      done_pulses++;
      if (done_cyc < 0) begin
        done_cyc = cyc; done_vec = done; err_at_done = err;
      end
    end
    if (err) err_pulses++;
    prev_start = spi_start; prev_stop = spi_stop; prev_cs = spi_cs_n;
  endtask

  task automatic run_txn(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      tick();
      if (done_cyc >= 0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] exp_order [4];

  initial begin
    rstn = 1'b0; req = 3'b000; len = 24'h01_01_01; tx_data = 24'h33_5A_11;
    spi_din = 8'h00; spi_load_next = 1'b0; spi_busy = 1'b0; spi_cs_n = 1'b1;
    e_st = 0; e_cnt = 0; din_idx = 0; nostrobe = 1'b0; drop_on_first = 1'b0;
    prev_start = 1'b0; prev_stop = 1'b0; prev_cs = 1'b1; cs_high_run = 0;
    din_tab[0] = 8'hA1; din_tab[1] = 8'hB2; din_tab[2] = 8'hC3; din_tab[3] = 8'hD4;
    clr();
    repeat (3) tick();

    // reset state
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_start", spi_start, 1'b0);
    chk("rst_stop", spi_stop, 1'b0);
    chk("rst_dout", spi_dout, 8'h00);
    rstn = 1'b1;
    tick();
    spi_load_next = 1'b1;
    #1;
    chk("idle_load_next_ignored", byte_next, 3'b000);
    spi_load_next = 1'b0;
    tick();

    // single requester 1, len=3
    clr();
    len = 24'h01_03_01;
    req = 3'b010;
    #1;
    chk("t1_gnt_before", gnt, 3'b000);
    tick();
    chk("t1_gnt_latency", gnt, 3'b010);
    chk("t1_start_pulse", spi_start, 1'b1);
    chk("t1_dout_owner", spi_dout, 8'h5A);
    tick();
    chk("t1_start_one_cycle", spi_start, 1'b0);
    run_txn(60);
    req = 3'b000;
    chk("t1_completed", done_cyc >= 0, 1'b1);
    chk("t1_stop_low_first_xfer", stop_first_xfer, 1'b0);
    chk("t1_byte_next_cnt", bn_cnt[1], 3);
    chk("t1_byte_next_total", bn_total, 3);
    chk("t1_stop_after_2nd", stop_rise_cyc - bn2_cyc, 1);
    chk("t1_done_vec", done_vec, 3'b010);
    chk("t1_done_gap", done_cyc - cs_rise_cyc, 4);
    chk("t1_no_err", err_at_done, 1'b0);
    tick(); tick();
    chk("t1_gnt_released", gnt, 3'b000);

    // all three requesting from reset, len=1 each
    rstn = 1'b0; req = 3'b111; len = 24'h01_01_01;
    tick();
    rstn = 1'b1;
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    for (int t = 0; t < 4; t++) begin
      clr();
      run_txn(80);
      chk($sformatf("t2_done_order_%0d", t), done_vec, exp_order[t]);
      chk($sformatf("t2_one_byte_%0d", t), bn_total, 1);
      if (t > 0) chk($sformatf("t2_cs_gap_%0d", t), run_at_start >= 5, 1'b1);
    end
    req = 3'b000;
    tick();

    // len=0 on requester 2
    clr();
    len = 24'h00_01_01;
    req = 3'b100;
    run_txn(60);
    req = 3'b000;
    chk("t3_done_vec", done_vec, 3'b100);
    chk("t3_byte_next_cnt", bn_cnt[2], 1);
    chk("t3_byte_next_total", bn_total, 1);
    chk("t3_stop_first_xfer", stop_first_xfer, 1'b1);
    tick();

    // stalled engine -> timeout abort, then next requester
    clr();
    nostrobe = 1'b1;
    len = 24'h01_01_04;
    req = 3'b011;
    run_txn(80);
    chk("t4_stop_forced_at", stop_rise_cyc - start_cyc, 16);
    chk("t4_done_vec", done_vec, 3'b001);
    chk("t4_err_with_done", err_at_done, 1'b1);
    chk("t4_err_pulses", err_pulses, 1);
    chk("t4_no_bytes", bn_total, 0);
    nostrobe = 1'b0;
    clr();
    run_txn(80);
    req = 3'b000;
    chk("t4_next_done_vec", done_vec, 3'b010);
    chk("t4_next_no_err", err_pulses, 0);
    tick();

    // reset mid-XFER
    clr();
    len = 24'h01_04_01;
    req = 3'b010;
    tick();
    chk("t5_gnt", gnt, 3'b010);
    repeat (3) tick();
    req = 3'b110;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t5_rst_gnt", gnt, 3'b000);
    chk("t5_rst_stop", spi_stop, 1'b0);
    chk("t5_rst_start", spi_start, 1'b0);
    chk("t5_rst_byte_next", byte_next, 3'b000);
    chk("t5_rst_dout", spi_dout, 8'h00);
    clr();
    tick();
    chk("t5_regrant_from_0", gnt, 3'b010);
    req = 3'b000;
    run_txn(80);
    chk("t5_done_vec", done_vec, 3'b010);
    chk("t5_full_len", bn_cnt[1], 4);
    tick();

    // requester 0 drops req after first byte, len=4
    clr();
    din_idx = 0;
    drop_on_first = 1'b1;
    len = 24'h01_01_04;
    req = 3'b001;
    run_txn(80);
    drop_on_first = 1'b0;
    repeat (10) tick();
    chk("t6_byte_next_cnt", bn_cnt[0], 4);
    chk("t6_done_vec", done_vec, 3'b001);
    chk("t6_done_once", done_pulses, 1);
    chk("t6_rx0", rx_cap[0], 8'hA1);
    chk("t6_rx1", rx_cap[1], 8'hB2);
    chk("t6_rx2", rx_cap[2], 8'hC3);
    chk("t6_rx3", rx_cap[3], 8'hD4);
    chk("t6_idle_after", gnt, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cc1200_spi_arbiter.md
Name: cc1200_spi_arbiter

Overview:
- Shares the single CC1200 byte-level SPI engine (Start/Stop/DataOut/DataIn/Load_Next/Busy/CS_n) between NREQ requesters.
- Typical requesters: RX-FIFO drain, TX stream, APB register access.
- Grants one length-framed transaction at a time, round-robin, and routes the byte stream and Load_Next strobes to the owner.
- Enforces a CS_n-high guard gap between transactions and aborts transactions that stall.

Parameters:
NREQ, 3, number of requesters (2..8)
GAP, 4, minimum clk cycles of CS_n high between transactions (1..255)
TIMEOUT, 65535, clk cycles with no spi_load_next in XFER before abort (>=16)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
req  in  NREQ  transaction request per requester, level, held until done/err
len  in  8*NREQ  bytes per transaction for requester i at [8i+7:8i]; 0 is treated as 1
tx_data  in  8*NREQ  current byte to send from requester i
gnt  out  NREQ  one-hot owner, held IDLE-exit to done
byte_next  out  NREQ  spi_load_next routed to owner; requester advances tx_data on it
rx_data  out  8  spi_din passed through, valid when byte_next pulses
done  out  NREQ  1-cycle pulse to owner on normal completion
err  out  1  1-cycle pulse on timeout abort, coincident with done of owner
spi_start  out  1  engine Start pulse
spi_stop  out  1  engine Stop level
spi_dout  out  8  engine DataOut = tx_data of owner, 0 when no owner
spi_din  in  8  engine DataIn
spi_load_next  in  1  engine byte strobe
spi_busy  in  1  engine Busy
spi_cs_n  in  1  engine CS_n

Behaviour:
- Reset, synchronous on clk while rstn=0: state=IDLE, gnt=0, done=0, err=0, spi_start=0, spi_stop=0, rr pointer=0, byte counter=0, gap counter=0, timeout counter=0.
- The same reset values apply mid-transaction. spi_stop=0 then; the engine is reset by the same rstn.
- States:
  - IDLE
    - If any req is set, pick the first set req at or after rr pointer, wrapping modulo NREQ.
    - Latch len (0 becomes 1) into lenq, set gnt, go to START.
    - Latency req to gnt: 1 cycle.
    - No req: stay in IDLE.
  - START
    - spi_start=1 for exactly this cycle. Byte counter=0, timeout counter=0. Go to XFER.
  - XFER
    - Each spi_load_next: byte_next[owner]=1 in the same cycle; byte counter +1; timeout counter cleared.
    - spi_stop = (byte counter == lenq-1), a level from entering that count until leaving XFER.
    - When spi_load_next occurs at count lenq-1: go to DRAIN.
    - Timeout counter reaches TIMEOUT: set abort flag, force spi_stop=1, go to DRAIN.
  - DRAIN
    - spi_stop held.
    - Wait for spi_cs_n=1 and spi_busy=0 in the same cycle, then go to GAP. Gap counter=1.
  - GAP
    - gnt still held. Count up each cycle.
    - When gap counter==GAP: pulse done[owner]; pulse err if abort flag is set.
    - In that same cycle: clear gnt and the abort flag, set rr pointer = owner+1 mod NREQ, go to IDLE.
    - A new grant can therefore occur at earliest 1 cycle after done.
- spi_dout is combinational from tx_data[owner]. The engine samples it at its own load points.
- Requests:
  - req dropped mid-transaction is ignored; the transaction completes with len bytes.
  - req still high after done is treated as a new request and arbitrated normally, so round-robin prevents monopolisation.
- Counters:
  - Byte counter is 8 bits; lenq=255 is legal, lenq=256 is not representable.
  - Timeout counter is 16 bits and saturates at TIMEOUT.
- A spi_load_next seen outside XFER is ignored; no byte_next is routed.

Test Plan:
- Single requester 1, len=3, engine model gives 3 spi_load_next:
  - gnt=3'b010 1 cycle after req.
  - spi_start pulse 1 cycle.
  - spi_stop rises after the 2nd byte_next.
  - done[1] pulses exactly GAP=4 cycles after spi_cs_n rises.
- All three req high from reset, len=1 each:
  - grant order 0,1,2,0.
  - ≥GAP+1 cycles of spi_cs_n high between successive spi_start pulses.
- len=0 on requester 2 -> exactly one byte_next[2], spi_stop high from the first XFER cycle.
- Engine model never asserts spi_load_next, TIMEOUT=16:
  - spi_stop forced high 16 cycles after spi_start.
  - After CS_n/busy release and the gap: err=1 and done[owner]=1 in the same cycle.
  - The next requester is then granted.
- rstn=0 asserted mid-XFER for 1 cycle -> next cycle all outputs 0, state IDLE; a pending req is granted in the following cycle starting at requester 0.
- Requester 0 drops req after 1st byte of len=4 -> still 4 byte_next[0] and one done[0]; rx_data equals the spi_din bytes 0xA1,0xB2,0xC3,0xD4 on those strobes.
